// File: rtl/ascon_msg_packer_if.sv
// Byte-stream input and padded-block output bundle for the Ascon message packer.
// slave is the packer side, master is the source/sink side.
interface ascon_msg_packer_if #(
  parameter int BW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          in_keep;
  logic          in_last;
  logic          blk_valid;
  logic          blk_ready;
  logic [BW-1:0] blk_data;
  logic          blk_last;

  modport slave (
    input  in_valid, in_byte, in_keep, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

  modport master (
    output in_valid, in_byte, in_keep, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/ascon_msg_packer.sv
// Packs a byte stream little-endian into 64-bit blocks and applies Ascon 10* padding
// (0x01 after the last byte, zeros above), adding a pad-only block when the message fills a block.
//
// state    | meaning
// FILL     | collecting bytes into lanes, in_ready = 1
// EMIT     | presenting a block (data or final padded block)
// EMIT_PAD | presenting a full final data block; pad-only block follows
module ascon_msg_packer #(
  parameter int BW = 64
) (
  input logic               clk,
  input logic               rst,
  ascon_msg_packer_if.slave bus
);
  localparam logic [1:0] FILL     = 2'd0;
  localparam logic [1:0] EMIT     = 2'd1;
  localparam logic [1:0] EMIT_PAD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] data_q, data_d;
  logic          last_q, last_d;

  logic [BW-1:0] wdata;
  logic [BW-1:0] padded;
  logic [3:0]    nbytes;

  // Lane write for the current beat, then the 10* padded view of the same block.
  always_comb begin
    wdata  = data_q;
    nbytes = {1'b0, idx_q};
    if (bus.in_keep) begin
      wdata[{idx_q, 3'b000} +: 8] = bus.in_byte;
      nbytes = {1'b0, idx_q} + 4'd1;
    end
    padded = wdata;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(nbytes)) padded[8*i +: 8] = 8'h01;
      else if (i > int'(nbytes)) padded[8*i +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            idx_d = 3'd0;
            if (nbytes == 4'd8) begin
              state_d = EMIT_PAD;
              data_d  = wdata;
              last_d  = 1'b0;
            end else begin
              state_d = EMIT;
              data_d  = padded;
              last_d  = 1'b1;
            end
          end else if (bus.in_keep) begin
            data_d = wdata;
            if (idx_q == 3'd7) begin
              state_d = EMIT;
              idx_d   = 3'd0;
              last_d  = 1'b0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      EMIT: begin
        if (bus.blk_ready) begin
          state_d = FILL;
          data_d  = '0;
          last_d  = 1'b0;
          idx_d   = 3'd0;
        end
      end
      EMIT_PAD: begin
        if (bus.blk_ready) begin
          state_d = EMIT;
          data_d  = BW'(1);
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        data_d  = '0;
        last_d  = 1'b0;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.blk_valid = (state_q != FILL);
  assign bus.blk_data  = data_q;
  assign bus.blk_last  = last_q;
endmodule

// File: tb/tb_ascon_msg_packer.sv
// Directed bench for ascon_msg_packer: an independent padding model fills a scoreboard,
// a negedge monitor pops and compares every consumed block.
module tb_ascon_msg_packer;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [64:0] sb[$];

  ascon_msg_packer_if #(.BW(64)) ifc ();

  ascon_msg_packer #(.BW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ascon padding model: append 0x01, zero-fill to a block multiple, mark final block.
  task automatic push_expected(input byte_q_t msg);
    byte_q_t p;
    int nblk;
    logic [63:0] d;
    p = msg;
    p.push_back(8'h01);
    while ((p.size() % 8) != 0) p.push_back(8'h00);
    nblk = p.size() / 8;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = p[8*b + k];
      sb.push_back({(b == nblk - 1), d});
    end
  endtask

  // Block monitor and hold-stability check under backpressure.
  logic        stall_prev = 1'b0;
  logic [63:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && ifc.blk_valid && ifc.blk_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_block observed=%h expected=none", ifc.blk_data);
      end else begin
        e = sb.pop_front();
        check("blk_data", ifc.blk_data, e[63:0]);
        check("blk_last", 64'(ifc.blk_last), 64'(e[64]));
      end
    end
    if (!rst && ifc.blk_valid && !ifc.blk_ready) begin
      if (stall_prev) begin
        check("hold_data", ifc.blk_data, hold_data);
        check("hold_last", 64'(ifc.blk_last), 64'(hold_last));
      end
      stall_prev = 1'b1;
      hold_data  = ifc.blk_data;
      hold_last  = ifc.blk_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send_beat(input logic [7:0] b, input logic keep, input logic last, output int waits);
    logic rdy;
    ifc.in_valid = 1'b1;
    ifc.in_byte  = b;
    ifc.in_keep  = keep;
    ifc.in_last  = last;
    waits = 0;
    do begin
      @(negedge clk);
      rdy = ifc.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!rdy && waits < 40);
    if (!rdy) check("beat_accept_timeout", 64'(0), 64'(1));
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg);
    int w;
    push_expected(msg);
    if (msg.size() == 0) send_beat(8'h00, 1'b0, 1'b1, w);
    else
      for (int i = 0; i < msg.size(); i++)
        send_beat(msg[i], 1'b1, (i == msg.size() - 1), w);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || ifc.blk_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    byte_q_t m;
    int w;
    ifc.in_valid  = 1'b0;
    ifc.in_byte   = 8'h00;
    ifc.in_keep   = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.blk_ready = 1'b1;
    #2;
    check("rst_in_ready",  64'(ifc.in_ready),  64'(1));
    check("rst_blk_valid", 64'(ifc.blk_valid), 64'(0));
    check("rst_blk_data",  ifc.blk_data,       64'h0);
    check("rst_blk_last",  64'(ifc.blk_last),  64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Empty message, sent on the first edge after reset release.
    push_expected(m);
    send_beat(8'h00, 1'b0, 1'b1, w);
    check("first_edge_accept", 64'(w), 64'(1));
    drain("empty");

    m = '{8'hAA, 8'hBB, 8'hCC};
    send_msg(m);
    drain("short");

    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_msg(m);
    drain("full_block");

    m = '{};
    for (int i = 0; i <= 10; i++) m.push_back(8'(i));
    send_msg(m);
    drain("multi_block");

    // Marker beat without data mid-message must be dropped.
    m = '{8'h11, 8'h22};
    push_expected(m);
    send_beat(8'h11, 1'b1, 1'b0, w);
    send_beat(8'h99, 1'b0, 1'b0, w);
    send_beat(8'h22, 1'b1, 1'b1, w);
    drain("keep0_drop");

    // Backpressure: block held for 5 cycles while junk beats are offered.
    ifc.blk_ready = 1'b0;
    m = '{8'hDE, 8'hAD, 8'hBE};
    send_msg(m);
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_byte  = 8'h77;
      ifc.in_keep  = 1'b1;
      ifc.in_last  = 1'b1;
      @(negedge clk);
      check("bp_in_ready",  64'(ifc.in_ready),  64'(0));
      check("bp_blk_valid", 64'(ifc.blk_valid), 64'(1));
      check("bp_blk_data",  ifc.blk_data,       64'h0000000001BEADDE);
      @(posedge clk); #1;
    end
    ifc.in_valid  = 1'b0;
    ifc.blk_ready = 1'b1;
    drain("backpressure");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_extra", 64'(ifc.blk_valid), 64'(0));

    // Reset mid-message discards the partial block.
    send_beat(8'h10, 1'b1, 1'b0, w);
    send_beat(8'h20, 1'b1, 1'b0, w);
    send_beat(8'h30, 1'b1, 1'b0, w);
    rst = 1'b1;
    #1;
    check("mid_rst_blk_data", ifc.blk_data,      64'h0);
    check("mid_rst_in_ready", 64'(ifc.in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    m = '{8'h55};
    send_msg(m);
    drain("reset_mid");

    // Reset while a pad block is pending behind a stalled full block.
    ifc.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'hE0 + 8'(i), 1'b1, (i == 7), w);
    @(negedge clk);
    check("pad_pending_valid", 64'(ifc.blk_valid), 64'(1));
    check("pad_pending_last",  64'(ifc.blk_last),  64'(0));
    #1;
    rst = 1'b1;
    #1;
    check("pad_rst_valid", 64'(ifc.blk_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.blk_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pad_discarded", 64'(ifc.blk_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ascon_msg_packer.md
ASCON_MSG_PACKER -- requirements
Module: ascon_msg_packer

Interface
REQ-001 SHALL have parameter BW, default 64, block width in bits; only 64 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  byte-stream valid.
REQ-005 SHALL have port in_ready  output  1  byte-stream ready.
REQ-006 SHALL have port in_byte  input  8  message byte.
REQ-007 SHALL have port in_keep  input  1  1 = in_byte carries data, 0 = no data byte (empty-message / marker beat).
REQ-008 SHALL have port in_last  input  1  final beat of the message.
REQ-009 SHALL have port blk_valid  output  1  padded block valid, towards the hash datapath.
REQ-010 SHALL have port blk_ready  input  1  hash datapath accepts the block.
REQ-011 SHALL have port blk_data  output  BW  packed 64-bit block.
REQ-012 SHALL have port blk_last  output  1  block is the final padded block of the message.

Function
REQ-013 SHALL treat a beat as accepted when in_valid and in_ready are both 1 on a rising clk edge, and a block as consumed when blk_valid and blk_ready are both 1.
REQ-014 SHALL implement the states FILL, EMIT and EMIT_PAD, with in_ready = 1 only in FILL (combinational from state).
REQ-015 SHALL keep a 3-bit byte index idx (0..7) giving the next free byte lane in FILL.
REQ-016 SHALL pack little-endian: an accepted data byte (in_keep=1) is written to blk_data[8*idx+7 : 8*idx], then idx increments.
REQ-017 SHALL drop an accepted beat with in_keep=0 and in_last=0, leaving idx and data unchanged.
REQ-018 SHALL, when an accepted non-last data byte fills lane 7, go to EMIT with blk_last=0 and idx=0.
REQ-019 SHALL, on an accepted last beat yielding n data bytes in the block (n = idx after any write, 0..7), write 0x01 into lane n, zero all lanes above n, set blk_last=1 and go to EMIT.
REQ-020 SHALL, on an accepted last data byte that fills lane 7 (n = 8), go to EMIT_PAD presenting that full block with blk_last=0.
REQ-021 SHALL, in EMIT_PAD on block consumption, load blk_data = 64'h0000000000000001, blk_last=1, and go to EMIT.
REQ-022 SHALL, in EMIT on block consumption, clear blk_data to 0, blk_last to 0, idx to 0, and return to FILL.
REQ-023 SHALL assert blk_valid in EMIT and EMIT_PAD only, one cycle after the accepting beat (latency 1).
REQ-024 SHALL hold blk_data and blk_last stable while blk_valid=1 and blk_ready=0.
REQ-025 SHALL ignore in_valid, in_byte, in_keep and in_last while in_ready=0.
REQ-026 SHALL clear unused lanes to zero at the start of each block so no stale bytes leak into a padded block.
REQ-027 SHALL sustain one block per 9 cycles with no backpressure (8 fill beats + 1 emit cycle).

Reset
REQ-028 SHALL, while rst=1 (asynchronously), force state=FILL, idx=0, blk_valid=0, blk_data=0, blk_last=0, hence in_ready=1.
REQ-029 SHALL discard any partially packed block or pending pad block when rst asserts mid-message; no block is emitted for it after rst deasserts.
REQ-030 SHALL accept a beat on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover empty message: one beat in_keep=0, in_last=1 -> one block 64'h0000000000000001, blk_last=1.
REQ-032 SHALL cover short message: bytes AA, BB, CC (last on CC) -> 64'h0000000001CCBBAA, blk_last=1.
REQ-033 SHALL cover full-block boundary: bytes 01..08 (last on 08) -> 64'h0807060504030201 blk_last=0, then 64'h0000000000000001 blk_last=1.
REQ-034 SHALL cover multi-block: bytes 00..0A (11 bytes, last on 0A) -> 64'h0706050403020100 blk_last=0, then 64'h00000000010A0908 blk_last=1.
REQ-035 SHALL cover backpressure: blk_ready=0 for 5 cycles during EMIT -> blk_data/blk_last stable, in_ready=0, in_valid beats not accepted.
REQ-036 SHALL cover reset mid-operation: rst pulsed after 3 bytes, then byte 55 with in_last=1 -> only 64'h0000000000000155, blk_last=1.
